// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready stage register with a DEPTH-entry in-order buffer.
// Define PIPE_STAGE_STALL_MARK_EN to enable the head_wait flag driving out_stalled.
module pipe_stage_buf #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_stalled,
  output logic [CW-1:0]    count
);

  generate
    if (!(DEPTH == 1 || DEPTH == 2 || DEPTH == 4 || DEPTH == 8)) begin : g_bad_depth
      $error("pipe_stage_buf: DEPTH must be 1, 2, 4 or 8");
    end
  endgenerate

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    if (DEPTH == 1) return '0;
    return PW'(p + 1'b1);
  endfunction

  // in_ready uses only registered state plus reset, never out_ready
  assign in_ready  = reset && (r_cnt != CW'(DEPTH));
  assign out_valid = (r_cnt != '0);
  assign out_data  = out_valid ? r_mem[r_rp] : '0;
  assign count     = r_cnt;

  assign w_push = in_valid && in_ready && !flush;
  assign w_pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= f_inc(r_wp);
      if (w_pop)  r_rp <= f_inc(r_rp);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

`ifdef PIPE_STAGE_STALL_MARK_EN
  logic r_head_wait;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head_wait <= 1'b0;
    end else if (flush || w_pop) begin
      r_head_wait <= 1'b0;
    end else if (out_valid && !out_ready) begin
      r_head_wait <= 1'b1;
    end
  end

  assign out_stalled = out_valid && r_head_wait;
`else
  assign out_stalled = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed checks of pipe_stage_buf at DEPTH 2, 4 and 8.
// Stalled-mark expectations follow PIPE_STAGE_STALL_MARK_EN.
module tb_pipe_stage_buf;

`ifdef PIPE_STAGE_STALL_MARK_EN
  localparam logic STL = 1'b1;
`else
  localparam logic STL = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  logic        a_flush = 0, a_iv = 0, a_ir, a_ov, a_or = 0, a_st;
  logic [63:0] a_id = '0, a_od;
  logic [1:0]  a_cnt;
  logic        b_flush = 0, b_iv = 0, b_ir, b_ov, b_or = 0, b_st;
  logic [63:0] b_id = '0, b_od;
  logic [2:0]  b_cnt;
  logic        c_flush = 0, c_iv = 0, c_ir, c_ov, c_or = 0, c_st;
  logic [63:0] c_id = '0, c_od;
  logic [3:0]  c_cnt;

  pipe_stage_buf #(.WIDTH(64), .DEPTH(2)) u_a (
    .clk(clk), .reset(reset), .flush(a_flush),
    .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
    .out_stalled(a_st), .count(a_cnt));

  pipe_stage_buf #(.WIDTH(64), .DEPTH(4)) u_b (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
    .out_stalled(b_st), .count(b_cnt));

  pipe_stage_buf #(.WIDTH(64), .DEPTH(8)) u_c (
    .clk(clk), .reset(reset), .flush(c_flush),
    .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
    .out_valid(c_ov), .out_ready(c_or), .out_data(c_od),
    .out_stalled(c_st), .count(c_cnt));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    n_cmp++; if (a_ir !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b want 0", a_ir); end
    n_cmp++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", a_ov); end
    n_cmp++; if (a_cnt !== 2'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", a_cnt); end
    n_cmp++; if (a_od !== 64'd0) begin n_fail++; $display("FAIL rst_out_data got %0h want 0", a_od); end
    n_cmp++; if (a_st !== 1'b0) begin n_fail++; $display("FAIL rst_stalled got %b want 0", a_st); end
    step(); step();
    reset = 1'b1;
    #1;
    n_cmp++; if (a_ir !== 1'b1) begin n_fail++; $display("FAIL rst_rel_in_ready got %b want 1", a_ir); end
    step();
  endtask

  task automatic test_fill();
    a_or = 0; a_iv = 1; a_id = 64'hA;
    step();
    n_cmp++; if (a_cnt !== 2'd1) begin n_fail++; $display("FAIL fill1_count got %0d want 1", a_cnt); end
    n_cmp++; if (a_od !== 64'hA) begin n_fail++; $display("FAIL fill1_data got %0h want a", a_od); end
    n_cmp++; if (a_st !== 1'b0) begin n_fail++; $display("FAIL fill1_stalled got %b want 0", a_st); end
    a_id = 64'hB;
    step();
    n_cmp++; if (a_cnt !== 2'd2) begin n_fail++; $display("FAIL fill2_count got %0d want 2", a_cnt); end
    n_cmp++; if (a_ir !== 1'b0) begin n_fail++; $display("FAIL fill2_in_ready got %b want 0", a_ir); end
    n_cmp++; if (a_od !== 64'hA) begin n_fail++; $display("FAIL fill2_data got %0h want a", a_od); end
    n_cmp++; if (a_st !== STL) begin n_fail++; $display("FAIL fill2_stalled got %b want %b", a_st, STL); end
    a_id = 64'hC;
    step();
    n_cmp++; if (a_cnt !== 2'd2) begin n_fail++; $display("FAIL fill3_count got %0d want 2", a_cnt); end
    n_cmp++; if (a_od !== 64'hA) begin n_fail++; $display("FAIL fill3_data got %0h want a", a_od); end
    n_cmp++; if (a_st !== STL) begin n_fail++; $display("FAIL fill3_stalled got %b want %b", a_st, STL); end
    a_iv = 0; a_or = 1;
    step();
    n_cmp++; if (a_od !== 64'hB) begin n_fail++; $display("FAIL drain1_data got %0h want b", a_od); end
    n_cmp++; if (a_cnt !== 2'd1) begin n_fail++; $display("FAIL drain1_count got %0d want 1", a_cnt); end
    n_cmp++; if (a_st !== 1'b0) begin n_fail++; $display("FAIL drain1_stalled got %b want 0", a_st); end
    step();
    n_cmp++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL drain2_valid got %b want 0", a_ov); end
    n_cmp++; if (a_od !== 64'd0) begin n_fail++; $display("FAIL drain2_data got %0h want 0 (C leaked?)", a_od); end
    a_or = 0;
  endtask

  task automatic test_back_to_back();
    a_or = 1;
    for (int i = 1; i <= 8; i++) begin
      a_iv = 1; a_id = 64'(i);
      step();
      n_cmp++; if (a_od !== 64'(i)) begin n_fail++; $display("FAIL b2b_data[%0d] got %0h want %0h", i, a_od, i); end
      n_cmp++; if (a_cnt !== 2'd1) begin n_fail++; $display("FAIL b2b_count[%0d] got %0d want 1", i, a_cnt); end
      n_cmp++; if (a_ir !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d] got %b want 1", i, a_ir); end
    end
    a_iv = 0;
    step();
    n_cmp++; if (a_cnt !== 2'd0) begin n_fail++; $display("FAIL b2b_end_count got %0d want 0", a_cnt); end
    a_or = 0;
  endtask

  task automatic test_wrap();
    logic [63:0] q[$];
    int pushed = 0;
    int popped = 0;
    int cyc = 0;
    while (popped < 6 && cyc < 40) begin
      b_iv = (pushed < 6);
      b_id = 64'h10 + 64'(pushed);
      b_or = cyc[0];
      n_cmp++; if (b_ov !== (q.size() != 0)) begin n_fail++; $display("FAIL wrap_valid[%0d] got %b want %b", cyc, b_ov, q.size() != 0); end
      if (b_ov && b_or) begin
        n_cmp++; if (b_od !== q[0]) begin n_fail++; $display("FAIL wrap_data[%0d] got %0h want %0h", popped, b_od, q[0]); end
        void'(q.pop_front());
        popped++;
      end
      if (b_iv && b_ir) begin
        q.push_back(b_id);
        pushed++;
      end
      step();
      n_cmp++; if (b_cnt !== 3'(q.size())) begin n_fail++; $display("FAIL wrap_count[%0d] got %0d want %0d", cyc, b_cnt, q.size()); end
      cyc++;
    end
    b_iv = 0; b_or = 0;
    n_cmp++; if (popped != 6) begin n_fail++; $display("FAIL wrap_timeout popped %0d want 6", popped); end
    n_cmp++; if (b_od !== 64'd0) begin n_fail++; $display("FAIL wrap_empty_data got %0h want 0", b_od); end
  endtask

  task automatic test_flush();
    a_or = 0; a_iv = 1; a_id = 64'h21;
    step();
    a_id = 64'h22;
    step();
    n_cmp++; if (a_cnt !== 2'd2) begin n_fail++; $display("FAIL flush_pre_count got %0d want 2", a_cnt); end
    a_flush = 1; a_id = 64'hF;
    step();
    a_flush = 0; a_iv = 0;
    n_cmp++; if (a_cnt !== 2'd0) begin n_fail++; $display("FAIL flush_count got %0d want 0", a_cnt); end
    n_cmp++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", a_ov); end
    n_cmp++; if (a_od !== 64'd0) begin n_fail++; $display("FAIL flush_data got %0h want 0", a_od); end
    n_cmp++; if (a_st !== 1'b0) begin n_fail++; $display("FAIL flush_stalled got %b want 0", a_st); end
    a_iv = 1; a_id = 64'h33;
    step();
    a_iv = 0;
    n_cmp++; if (a_od !== 64'h33) begin n_fail++; $display("FAIL flush_after_data got %0h want 33", a_od); end
    n_cmp++; if (a_cnt !== 2'd1) begin n_fail++; $display("FAIL flush_after_count got %0d want 1", a_cnt); end
    a_or = 1;
    step();
    a_or = 0;
  endtask

  task automatic test_async_reset();
    c_or = 0; c_iv = 1;
    for (int i = 0; i < 5; i++) begin
      c_id = 64'h40 + 64'(i);
      step();
    end
    c_iv = 0;
    n_cmp++; if (c_cnt !== 4'd5) begin n_fail++; $display("FAIL arst_pre_count got %0d want 5", c_cnt); end
    n_cmp++; if (c_od !== 64'h40) begin n_fail++; $display("FAIL arst_pre_data got %0h want 40", c_od); end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (c_ov !== 1'b0) begin n_fail++; $display("FAIL arst_valid got %b want 0", c_ov); end
    n_cmp++; if (c_cnt !== 4'd0) begin n_fail++; $display("FAIL arst_count got %0d want 0", c_cnt); end
    n_cmp++; if (c_ir !== 1'b0) begin n_fail++; $display("FAIL arst_in_ready got %b want 0", c_ir); end
    n_cmp++; if (c_od !== 64'd0) begin n_fail++; $display("FAIL arst_data got %0h want 0", c_od); end
    step();
    n_cmp++; if (c_ir !== 1'b0) begin n_fail++; $display("FAIL arst_hold_in_ready got %b want 0", c_ir); end
    reset = 1'b1;
    #1;
    n_cmp++; if (c_ir !== 1'b1) begin n_fail++; $display("FAIL arst_rel_in_ready got %b want 1", c_ir); end
    step();
    c_iv = 1; c_id = 64'h55;
    step();
    c_iv = 0;
    n_cmp++; if (c_od !== 64'h55) begin n_fail++; $display("FAIL arst_new_data got %0h want 55", c_od); end
    n_cmp++; if (c_cnt !== 4'd1) begin n_fail++; $display("FAIL arst_new_count got %0d want 1", c_cnt); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
